// File: rtl/countdown_timer_ctrl_if.sv
// Control/status bundle between the button logic, the countdown controller and the display driver.
// load and start_pause are single-cycle pulses sampled on clk; outputs are registered state views.
interface countdown_timer_ctrl_if;
    logic       load;
    logic       start_pause;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
    logic [7:0] min_out;
    logic [7:0] sec_out;
    logic       running;
    logic       done;
    logic [1:0] dbg_state;

    modport master (
        output load, start_pause, preset_min, preset_sec,
        input  min_out, sec_out, running, done, dbg_state
    );

    modport slave (
        input  load, start_pause, preset_min, preset_sec,
        output min_out, sec_out, running, done, dbg_state
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown controller: run/pause/done FSM, tick prescaler and a four-stage BCD borrow chain.
// The chain only moves on a prescaler tick while running and stops by entering DONE at 00:00.
module countdown_timer_ctrl #(
    parameter int TICK_DIV = 100000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    countdown_timer_ctrl_if.slave   io_tmr
);

    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic [3:0]    r_sec_o, r_sec_t, r_min_o, r_min_t;
    logic [3:0]    w_sec_o_nxt, w_sec_t_nxt, w_min_o_nxt, w_min_t_nxt;
    logic          w_tick;
    logic          w_zero;
    logic          w_one;
    logic          w_b0, w_b1, w_b2;

    function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign w_tick = (r_state == S_RUN) && (r_presc == PMAX);
    assign w_zero = (r_min_t == 4'd0) && (r_min_o == 4'd0) && (r_sec_t == 4'd0) && (r_sec_o == 4'd0);
    assign w_one  = (r_min_t == 4'd0) && (r_min_o == 4'd0) && (r_sec_t == 4'd0) && (r_sec_o == 4'd1);

    // Borrow ripples from seconds-ones upward; each stage only moves on its lower neighbour's borrow.
    assign w_b0 = (r_sec_o == 4'd0);
    assign w_b1 = w_b0 && (r_sec_t == 4'd0);
    assign w_b2 = w_b1 && (r_min_o == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_sec_o <= 4'd0;
            r_sec_t <= 4'd0;
            r_min_o <= 4'd0;
            r_min_t <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_sec_o <= w_sec_o_nxt;
            r_sec_t <= w_sec_t_nxt;
            r_min_o <= w_min_o_nxt;
            r_min_t <= w_min_t_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        if (io_tmr.load) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_tmr.start_pause && !w_zero) begin
                        w_state_nxt = S_RUN;
                        w_presc_nxt = '0;
                    end
                end
                S_RUN: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
                    // Reaching 00:00 outranks a pause request in the same cycle.
                    if (w_tick && w_one) begin
                        w_state_nxt = S_DONE;
                    end else if (io_tmr.start_pause) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (io_tmr.start_pause) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_DONE;
                end
            endcase
        end
    end

    always_comb begin
        w_sec_o_nxt = r_sec_o;
        w_sec_t_nxt = r_sec_t;
        w_min_o_nxt = r_min_o;
        w_min_t_nxt = r_min_t;
        if (io_tmr.load) begin
            w_min_t_nxt = clamp_digit(io_tmr.preset_min[7:4], 4'd5);
            w_min_o_nxt = clamp_digit(io_tmr.preset_min[3:0], 4'd9);
            w_sec_t_nxt = clamp_digit(io_tmr.preset_sec[7:4], 4'd5);
            w_sec_o_nxt = clamp_digit(io_tmr.preset_sec[3:0], 4'd9);
        end else if (w_tick && !w_zero) begin
            w_sec_o_nxt = w_b0 ? 4'd9 : r_sec_o - 4'd1;
            if (w_b0) begin
                w_sec_t_nxt = (r_sec_t == 4'd0) ? 4'd5 : r_sec_t - 4'd1;
            end
            if (w_b1) begin
                w_min_o_nxt = (r_min_o == 4'd0) ? 4'd9 : r_min_o - 4'd1;
            end
            if (w_b2) begin
                w_min_t_nxt = (r_min_t == 4'd0) ? 4'd5 : r_min_t - 4'd1;
            end
        end
    end

    assign io_tmr.min_out   = {r_min_t, r_min_o};
    assign io_tmr.sec_out   = {r_sec_t, r_sec_o};
    assign io_tmr.running   = (r_state == S_RUN);
    assign io_tmr.done      = (r_state == S_DONE);
    assign io_tmr.dbg_state = r_state;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed plus randomized checks of countdown_timer_ctrl against a seconds-based reference model.
module tb_countdown_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk;
  logic rst_n;
  countdown_timer_ctrl_if tmr_if ();

  countdown_timer_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_tmr(tmr_if.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_val;   // remaining time in seconds
  int m_mode;
  int m_cnt;   // cycles spent in RUN since the last tick
  int n_checks;
  int n_fail;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int preset_secs(input logic [7:0] pm, input logic [7:0] ps);
    int mt, mo, st, so;
    mt = (pm[7:4] > 4'd5) ? 5 : int'(pm[7:4]);
    mo = (pm[3:0] > 4'd9) ? 9 : int'(pm[3:0]);
    st = (ps[7:4] > 4'd5) ? 5 : int'(ps[7:4]);
    so = (ps[3:0] > 4'd9) ? 9 : int'(ps[3:0]);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  task automatic model_reset();
    m_val  = 0;
    m_mode = M_IDLE;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic l, input logic sp, input logic [7:0] pm, input logic [7:0] ps);
    bit tick;
    if (l) begin
      m_val  = preset_secs(pm, ps);
      m_mode = M_IDLE;
      m_cnt  = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (sp && m_val != 0) begin m_mode = M_RUN; m_cnt = 0; end
        M_RUN: begin
          tick  = (m_cnt == TICK_DIV - 1);
          m_cnt = tick ? 0 : m_cnt + 1;
          if (tick) m_val = m_val - 1;
          if (tick && m_val == 0) m_mode = M_DONE;
          else if (sp) m_mode = M_PAUSE;
        end
        M_PAUSE: if (sp) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".min"},     tmr_if.min_out, to_bcd(m_val / 60));
    check({tag, ".sec"},     tmr_if.sec_out, to_bcd(m_val % 60));
    check({tag, ".running"}, {7'd0, tmr_if.running}, {7'd0, m_mode == M_RUN});
    check({tag, ".done"},    {7'd0, tmr_if.done}, {7'd0, m_mode == M_DONE});
    check({tag, ".state"},   {6'd0, tmr_if.dbg_state}, 8'(m_mode));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic l, input logic sp, input string tag);
    tmr_if.load        = l;
    tmr_if.start_pause = sp;
    @(posedge clk);
    model_step(l, sp, tmr_if.preset_min, tmr_if.preset_sec);
    #1;
    check_model(tag);
    @(negedge clk);
    tmr_if.load        = 1'b0;
    tmr_if.start_pause = 1'b0;
  endtask

  task automatic load_preset(input logic [7:0] pm, input logic [7:0] ps, input logic sp, input string tag);
    tmr_if.preset_min = pm;
    tmr_if.preset_sec = ps;
    step(1'b1, sp, tag);
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic l, sp;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    tmr_if.load = 1'b0;
    tmr_if.start_pause = 1'b0;
    tmr_if.preset_min = 8'h00;
    tmr_if.preset_sec = 8'h00;
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 01:05 full countdown
    load_preset(8'h01, 8'h05, 1'b0, "t1.load");
    step(1'b0, 1'b1, "t1.start");
    check("t1.running", {7'd0, tmr_if.running}, 8'd1);
    idle_steps(4, "t1.run");
    check("t1.first_tick", tmr_if.sec_out, 8'h04);
    idle_steps(20, "t1.run");
    check("t1.min_0059", tmr_if.min_out, 8'h00);
    check("t1.sec_0059", tmr_if.sec_out, 8'h59);
    idle_steps(236, "t1.run");
    check("t1.done", {7'd0, tmr_if.done}, 8'd1);
    check("t1.end_sec", tmr_if.sec_out, 8'h00);
    step(1'b0, 1'b1, "t1.sp_in_done");
    check("t1.stay_done", {6'd0, tmr_if.dbg_state}, 8'(M_DONE));

    // 2: pause holds the prescaler
    load_preset(8'h00, 8'h03, 1'b0, "t2.load");
    step(1'b0, 1'b1, "t2.start");
    step(1'b0, 1'b0, "t2.run");
    step(1'b0, 1'b1, "t2.pause");
    idle_steps(20, "t2.frozen");
    check("t2.frozen_sec", tmr_if.sec_out, 8'h03);
    step(1'b0, 1'b1, "t2.resume");
    step(1'b0, 1'b0, "t2.resume1");
    check("t2.not_yet", tmr_if.sec_out, 8'h03);
    step(1'b0, 1'b0, "t2.resume2");
    check("t2.tick_after_2", tmr_if.sec_out, 8'h02);

    // 3: zero preset and clamping
    load_preset(8'h00, 8'h00, 1'b0, "t3.load0");
    step(1'b0, 1'b1, "t3.sp_zero");
    check("t3.idle", {6'd0, tmr_if.dbg_state}, 8'(M_IDLE));
    load_preset(8'h7A, 8'hFF, 1'b0, "t3.clamp");
    check("t3.clamp_min", tmr_if.min_out, 8'h59);
    check("t3.clamp_sec", tmr_if.sec_out, 8'h59);

    // 4: triple borrow, then load beats start_pause
    load_preset(8'h10, 8'h00, 1'b0, "t4.load");
    step(1'b0, 1'b1, "t4.start");
    idle_steps(4, "t4.run");
    check("t4.cascade_min", tmr_if.min_out, 8'h09);
    check("t4.cascade_sec", tmr_if.sec_out, 8'h59);
    load_preset(8'h00, 8'h10, 1'b1, "t4.load_sp");
    check("t4.reload_state", {6'd0, tmr_if.dbg_state}, 8'(M_IDLE));

    // 5: asynchronous reset mid-run
    load_preset(8'h00, 8'h05, 1'b0, "t5.load");
    step(1'b0, 1'b1, "t5.start");
    idle_steps(2, "t5.run");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("t5.async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, "t5.sp_after_rst");

    // 6: terminal tick coinciding with start_pause
    load_preset(8'h00, 8'h01, 1'b0, "t6.load");
    step(1'b0, 1'b1, "t6.start");
    idle_steps(3, "t6.run");
    step(1'b0, 1'b1, "t6.tick_sp");
    check("t6.done", {7'd0, tmr_if.done}, 8'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      l  = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 7) == 0);
      tmr_if.preset_min = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      tmr_if.preset_sec = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      step(l, sp, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
